baud_gen_os: RTL

// - Parametrised successor of the UART baud-rate tick generator. Divides clk_i
//   by a programmable divisor to produce an oversample tick (tick_os_o).
// - Further divides that tick by OVERSAMPLE to produce a bit-rate strobe (baud_o).
// - Feeds the UART RX sampler (tick_os_o) and the TX shifter (baud_o).
// - Divisor updates are shadowed so a rate change never yields a short period.
//

---
 rtl/baud_gen_os.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/baud_gen_os.sv
// Oversampling UART baud generator: programmable clk_i divider producing tick_os_o,
// further divided by OVERSAMPLE into baud_o. Optional fractional divisor: BAUD_FRAC_EN.
module baud_gen_os #(
  parameter int DIV_WIDTH  = 16,
  parameter int OVERSAMPLE = 16,
  parameter int OS_WIDTH   = 4,
  parameter int FRAC_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic [DIV_WIDTH-1:0]  divisor_i,
  input  logic [FRAC_WIDTH-1:0] frac_i,
  input  logic                  load_i,
  output logic                  tick_os_o,
  output logic                  baud_o,
  output logic [7:0]            status_o
);

  localparam logic [OS_WIDTH-1:0] OS_LAST = OS_WIDTH'(OVERSAMPLE - 1);

  // Counter reload for a divisor n, optionally stretched by one cycle.
  function automatic logic [DIV_WIDTH-1:0] reload_val(input logic [DIV_WIDTH-1:0] n,
                                                      input logic extra);
    logic [DIV_WIDTH-1:0] r;
    if (n == '0) r = '0;
    else         r = n - DIV_WIDTH'(1) + DIV_WIDTH'(extra);
    return r;
  endfunction

  logic [DIV_WIDTH-1:0] act_div, act_div_n;
  logic [DIV_WIDTH-1:0] shd_div, shd_div_n;
  logic [DIV_WIDTH-1:0] cnt, cnt_n;
  logic [DIV_WIDTH-1:0] nd;
  logic [OS_WIDTH-1:0]  os_cnt, os_cnt_n;
  logic                 pend, pend_n;
  logic                 tick_p1, tick_n;
  logic                 baud_p1, baud_n;
  logic                 div_zero_p1;
  logic                 running;
  logic                 carry;

`ifdef BAUD_FRAC_EN
  logic [FRAC_WIDTH-1:0] act_frac, act_frac_n;
  logic [FRAC_WIDTH-1:0] shd_frac, shd_frac_n;
  logic [FRAC_WIDTH-1:0] acc, acc_n;
  logic [FRAC_WIDTH-1:0] nf;
`else
  logic unused_frac;
  assign unused_frac = ^frac_i;
`endif

  assign running = enable_i && (act_div != '0);

  always_comb begin
    act_div_n = act_div;
    shd_div_n = shd_div;
    cnt_n     = cnt;
    os_cnt_n  = os_cnt;
    pend_n    = pend;
    tick_n    = 1'b0;
    baud_n    = 1'b0;
    nd        = act_div;
    carry     = 1'b0;
`ifdef BAUD_FRAC_EN
    act_frac_n = act_frac;
    shd_frac_n = shd_frac;
    acc_n      = acc;
    nf         = act_frac;
`endif

    if (load_i) begin
      shd_div_n = divisor_i;
      pend_n    = 1'b1;
`ifdef BAUD_FRAC_EN
      shd_frac_n = frac_i;
`endif
    end

    if (running) begin
      if (cnt == '0) begin
        tick_n = 1'b1;
        if (os_cnt == OS_LAST) begin
          os_cnt_n = '0;
          baud_n   = 1'b1;
        end else begin
          os_cnt_n = os_cnt + OS_WIDTH'(1);
        end
        // A load coinciding with terminal takes effect for the very next period.
        if (load_i) begin
          nd     = divisor_i;
          pend_n = 1'b0;
`ifdef BAUD_FRAC_EN
          nf = frac_i;
`endif
        end else if (pend) begin
          nd     = shd_div;
          pend_n = 1'b0;
`ifdef BAUD_FRAC_EN
          nf = shd_frac;
`endif
        end
        act_div_n = nd;
`ifdef BAUD_FRAC_EN
        act_frac_n     = nf;
        {carry, acc_n} = {1'b0, acc} + {1'b0, nf};
`endif
        cnt_n = reload_val(nd, carry);
      end else begin
        cnt_n = cnt - DIV_WIDTH'(1);
      end
    end else begin
      // Idle (disabled or N=0): shadow copies straight through, phase restarts clean.
      os_cnt_n = '0;
`ifdef BAUD_FRAC_EN
      acc_n = '0;
`endif
      if (pend) begin
        act_div_n = shd_div;
        pend_n    = load_i;
`ifdef BAUD_FRAC_EN
        act_frac_n = shd_frac;
`endif
      end
      cnt_n = reload_val(act_div_n, 1'b0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      act_div     <= '0;
      shd_div     <= '0;
      cnt         <= '0;
      os_cnt      <= '0;
      pend        <= 1'b0;
      tick_p1     <= 1'b0;
      baud_p1     <= 1'b0;
      div_zero_p1 <= 1'b0;
    end else begin
      act_div     <= act_div_n;
      shd_div     <= shd_div_n;
      cnt         <= cnt_n;
      os_cnt      <= os_cnt_n;
      pend        <= pend_n;
      tick_p1     <= tick_n;
      baud_p1     <= baud_n;
      div_zero_p1 <= (act_div_n == '0);
    end
  end

`ifdef BAUD_FRAC_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      act_frac <= '0;
      shd_frac <= '0;
      acc      <= '0;
    end else begin
      act_frac <= act_frac_n;
      shd_frac <= shd_frac_n;
      acc      <= acc_n;
    end
  end
`endif

  assign tick_os_o = tick_p1;
  assign baud_o    = baud_p1;
  assign status_o  = {4'b0000, div_zero_p1, pend, baud_p1, tick_p1};

endmodule
